// File: rtl/division_sequencer.sv
// Multi-cycle restoring radix-2 integer divider controller with a start/ready handshake.
// Divide-by-zero and signed overflow are resolved in one cycle; otherwise one quotient bit per cycle.

module divisionOverflowDetectionBlock #(
    parameter int width = 32
) (
    input  logic             signed_i,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    output logic             overflow_o
);
    assign overflow_o = signed_i && (dividend_i == {1'b1, {(width-1){1'b0}}}) && (&divisor_i);
endmodule

module division_sequencer #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] quotient_o,
    output logic [width-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             overflow_o
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [width-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [width-1:0] dvsa_q, dvsa_d, rem_q, rem_d, quo_q, quo_d;
    logic [width-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             dz_q, dz_d, ov_q, ov_d;
    logic             accept, ovf, neg_dvd, neg_dvs, ge;
    logic [width+1:0] trial;

    divisionOverflowDetectionBlock #(.width(width)) u_ovf (
        .signed_i  (sgn_q),
        .dividend_i(dvd_q),
        .divisor_i (dvs_q),
        .overflow_o(ovf)
    );

    assign ready_o     = (state_q == IDLE) || (state_q == DONE);
    assign busy_o      = (state_q == CHECK) || (state_q == ITER) || (state_q == FIX);
    assign done_o      = (state_q == DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = dz_q;
    assign overflow_o  = ov_q;

    // A flush in the same cycle as a would-be accept drops the request.
    assign accept  = start_i && ready_o && !flush_i;
    assign neg_dvd = sgn_q && dvd_q[width-1];
    assign neg_dvs = sgn_q && dvs_q[width-1];
    // Borrow in the top bit means the trial subtraction went negative.
    assign trial   = {1'b0, rem_q, quo_q[width-1]} - {2'b00, dvsa_q};
    assign ge      = !trial[width+1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvsa_d      = dvsa_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        if (accept) begin
            sgn_d   = signed_i;
            dvd_d   = dividend_i;
            dvs_d   = divisor_i;
            state_d = CHECK;
        end
        case (state_q)
            IDLE: ;
            CHECK: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dz_d        = 1'b1;
                    ov_d        = 1'b0;
                    state_d     = DONE;
                end else if (ovf) begin
                    quotient_d  = dvd_q;
                    remainder_d = '0;
                    dz_d        = 1'b0;
                    ov_d        = 1'b1;
                    state_d     = DONE;
                end else begin
                    quo_d   = neg_dvd ? -dvd_q : dvd_q;
                    dvsa_d  = neg_dvs ? -dvs_q : dvs_q;
                    rem_d   = '0;
                    cnt_d   = CW'(width);
                    state_d = ITER;
                end
            end
            ITER: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = ge ? width'(trial) : width'({rem_q, quo_q[width-1]});
                    quo_d = {quo_q[width-2:0], ge};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = FIX;
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    quotient_d  = (neg_dvd ^ neg_dvs) ? -quo_q : quo_q;
                    remainder_d = neg_dvd ? -rem_q : rem_q;
                    dz_d        = 1'b0;
                    ov_d        = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: if (!accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvsa_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvsa_q      <= dvsa_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
        end
    end
endmodule
